// File: rtl/pci_bus_arbiter.sv
// Central PCI bus arbiter: issues one GNT# at a time in FIFO or fixed-priority
// order, follows FRAME#/IRDY# bus ownership and revokes unused grants.
module pci_bus_arbiter #(
  parameter int unsigned N_REQ        = 8,
  parameter int unsigned GNT_TIMEOUT  = 16,
  localparam int unsigned ID_W        = $clog2(N_REQ),
  localparam int unsigned QC_W        = ID_W + 1,
  localparam int unsigned CNT_W       = $clog2(GNT_TIMEOUT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req_n,
  input  logic             frame_n,
  input  logic             irdy_n,
  input  logic             mode,
  output logic [N_REQ-1:0] gnt_n,
  output logic             gnt_valid,
  output logic [ID_W-1:0]  gnt_id,
  output logic [QC_W-1:0]  q_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2,
    TURN  = 2'd3
  } state_t;

  state_t                      state, state_nxt;
  logic [N_REQ-1:0][ID_W-1:0]  queue;
  logic [ID_W-1:0]             wr_ptr, wr_ptr_nxt;
  logic [ID_W-1:0]             rd_ptr, rd_ptr_nxt;
  logic [N_REQ-1:0]            pending, pending_nxt;
  logic [CNT_W-1:0]            cnt, cnt_nxt;
  logic                        mode_q, mode_q_nxt;
  logic [N_REQ-1:0]            gnt_n_nxt;
  logic                        gnt_valid_nxt;
  logic [ID_W-1:0]             gnt_id_nxt;
  logic [QC_W-1:0]             q_count_nxt;

  logic                        eff_mode;
  logic [ID_W-1:0]             head;
  logic [N_REQ-1:0]            granted_mask;
  logic [N_REQ-1:0]            enq_vec;
  logic                        enq;
  logic [ID_W-1:0]             enq_id;
  logic                        pop;
  logic                        flush;
  logic                        win_ok;
  logic [ID_W-1:0]             win_id;
  logic                        release_gnt;

  // Lowest set bit index of a request vector.
  function automatic logic [ID_W-1:0] lowest_idx(input logic [N_REQ-1:0] vec);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (vec[i]) idx = ID_W'(i);
    end
    return idx;
  endfunction

  // Mode is only re-sampled in IDLE; elsewhere the mode of the current tenure rules.
  always_comb begin
    eff_mode     = (state == IDLE) ? mode : mode_q;
    head         = queue[rd_ptr];
    granted_mask = gnt_valid ? (N_REQ'(1) << gnt_id) : '0;
    enq_vec      = ~req_n & ~pending & ~granted_mask;
    enq          = !eff_mode && (|enq_vec);
    enq_id       = lowest_idx(enq_vec);
  end

  always_comb begin
    state_nxt     = state;
    gnt_n_nxt     = gnt_n;
    gnt_valid_nxt = gnt_valid;
    gnt_id_nxt    = gnt_id;
    cnt_nxt       = cnt;
    mode_q_nxt    = mode_q;
    pop           = 1'b0;
    flush         = 1'b0;
    win_ok        = 1'b0;
    win_id        = '0;
    release_gnt   = 1'b0;

    case (state)
      IDLE: begin
        mode_q_nxt = mode;
        if (mode) begin
          flush = 1'b1;
          if (|(~req_n)) begin
            win_ok = 1'b1;
            win_id = lowest_idx(~req_n);
          end
        end else if (q_count != '0) begin
          // A head whose request was withdrawn is discarded without a grant.
          if (req_n[head]) begin
            pop = 1'b1;
          end else begin
            win_ok = 1'b1;
            win_id = head;
          end
        end
        if (win_ok) begin
          gnt_n_nxt     = ~(N_REQ'(1) << win_id);
          gnt_valid_nxt = 1'b1;
          gnt_id_nxt    = win_id;
          cnt_nxt       = '0;
          state_nxt     = GRANT;
        end
      end

      GRANT: begin
        if (!frame_n) begin
          release_gnt = 1'b1;
          pop         = !mode_q;
          state_nxt   = BUSY;
        end else if (req_n[gnt_id] || (cnt == CNT_W'(GNT_TIMEOUT - 1))) begin
          release_gnt = 1'b1;
          pop         = !mode_q;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      BUSY: begin
        if (frame_n && irdy_n) state_nxt = TURN;
      end

      TURN: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (release_gnt) begin
      gnt_n_nxt     = '1;
      gnt_valid_nxt = 1'b0;
    end
  end

  // Queue bookkeeping; one enqueue and one pop may coincide.
  always_comb begin
    wr_ptr_nxt  = wr_ptr;
    rd_ptr_nxt  = rd_ptr;
    pending_nxt = pending;
    q_count_nxt = q_count;
    if (flush) begin
      wr_ptr_nxt  = '0;
      rd_ptr_nxt  = '0;
      pending_nxt = '0;
      q_count_nxt = '0;
    end else begin
      if (pop) begin
        rd_ptr_nxt        = rd_ptr + ID_W'(1);
        pending_nxt[head] = 1'b0;
      end
      if (enq) begin
        wr_ptr_nxt          = wr_ptr + ID_W'(1);
        pending_nxt[enq_id] = 1'b1;
      end
      q_count_nxt = q_count + QC_W'(enq) - QC_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      gnt_n     <= '1;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      q_count   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pending   <= '0;
      cnt       <= '0;
      mode_q    <= 1'b0;
      queue     <= '0;
    end else begin
      state     <= state_nxt;
      gnt_n     <= gnt_n_nxt;
      gnt_valid <= gnt_valid_nxt;
      gnt_id    <= gnt_id_nxt;
      q_count   <= q_count_nxt;
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      pending   <= pending_nxt;
      cnt       <= cnt_nxt;
      mode_q    <= mode_q_nxt;
      if (enq) queue[wr_ptr] <= enq_id;
    end
  end

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Bench for pci_bus_arbiter: queue-based reference model feeding a per-cycle
// scoreboard, directed bus scenarios and a randomized run.
module tb_pci_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req_n;
  logic       frame_n;
  logic       irdy_n;
  logic       mode;
  logic [7:0] gnt_n;
  logic       gnt_valid;
  logic [2:0] gnt_id;
  logic [3:0] q_count;

  pci_bus_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_n     (req_n),
    .frame_n   (frame_n),
    .irdy_n    (irdy_n),
    .mode      (mode),
    .gnt_n     (gnt_n),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .q_count   (q_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] gn;
    logic       gv;
    logic [2:0] gid;
    logic [3:0] qc;
  } snap_t;

  snap_t exp_q[$];
  int    vectors     = 0;
  int    miscompares = 0;

  // Reference model: request order kept as a plain queue of initiator ids.
  typedef enum {PH_IDLE, PH_GRANT, PH_BUSY, PH_TURN} phase_t;
  phase_t   ph;
  int       order[$];
  bit [7:0] waiting;
  bit       owner_valid;
  int       owner;
  int       held;
  bit       mode_seen;

  task automatic model_reset();
    ph          = PH_IDLE;
    order.delete();
    waiting     = '0;
    owner_valid = 1'b0;
    owner       = 0;
    held        = 0;
    mode_seen   = 1'b0;
  endtask

  task automatic drop_owner();
    int h;
    owner_valid = 1'b0;
    if (!mode_seen) begin
      h = order.pop_front();
      waiting[h] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit use_fifo;
    int cand;
    int win;
    int h;
    use_fifo = (ph == PH_IDLE) ? !mode : !mode_seen;
    cand = -1;
    win  = -1;
    if (use_fifo) begin
      for (int i = 0; i < 8; i++)
        if (cand < 0 && !req_n[i] && !waiting[i] && !(owner_valid && owner == i)) cand = i;
    end
    case (ph)
      PH_IDLE: begin
        mode_seen = mode;
        if (mode) begin
          order.delete();
          waiting = '0;
          for (int i = 7; i >= 0; i--) if (!req_n[i]) win = i;
        end else if (order.size() > 0) begin
          h = order[0];
          if (req_n[h]) begin
            void'(order.pop_front());
            waiting[h] = 1'b0;
          end else begin
            win = h;
          end
        end
        if (win >= 0) begin
          owner_valid = 1'b1;
          owner       = win;
          held        = 0;
          ph          = PH_GRANT;
        end
      end
      PH_GRANT: begin
        if (!frame_n) begin
          drop_owner();
          ph = PH_BUSY;
        end else if (req_n[owner] || held + 1 == 16) begin
          drop_owner();
          ph = PH_IDLE;
        end else begin
          held++;
        end
      end
      PH_BUSY: if (frame_n && irdy_n) ph = PH_TURN;
      PH_TURN: ph = PH_IDLE;
      default: ph = PH_IDLE;
    endcase
    if (cand >= 0) begin
      order.push_back(cand);
      waiting[cand] = 1'b1;
    end
  endtask

  always @(posedge clk) begin : ref_model
    snap_t s;
    if (!reset) model_reset();
    else model_step();
    s.gn  = owner_valid ? ~(8'h01 << owner) : 8'hFF;
    s.gv  = owner_valid;
    s.gid = 3'(owner);
    s.qc  = 4'(order.size());
    exp_q.push_back(s);
  end

  // Monitor: compares every registered output set against the model's prediction.
  int         glog[$];
  logic [7:0] glog_n[$];
  int         qpeak = 0;
  logic       prev_gv = 1'b0;

  always @(negedge clk) begin : monitor
    snap_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (gnt_n !== e.gn || gnt_valid !== e.gv || gnt_id !== e.gid || q_count !== e.qc) begin
        miscompares++;
        $display("FAIL cycle_check t=%0t: dut gnt_n=%h valid=%b id=%0d q=%0d, expected gnt_n=%h valid=%b id=%0d q=%0d",
                 $time, gnt_n, gnt_valid, gnt_id, q_count, e.gn, e.gv, e.gid, e.qc);
      end
    end
    if (gnt_valid === 1'b1 && !prev_gv) begin
      glog.push_back(int'(gnt_id));
      glog_n.push_back(gnt_n);
    end
    prev_gv = gnt_valid;
    if (int'(q_count) > qpeak) qpeak = int'(q_count);
  end

  task automatic check_val(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int glog_at(input int idx);
    return (idx < glog.size()) ? glog[idx] : -1;
  endfunction

  function automatic int glog_n_at(input int idx);
    return (idx < glog_n.size()) ? int'(glog_n[idx]) : -1;
  endfunction

  // Bus master emulation: after resp_delay granted cycles, runs a FRAME# of resp_len cycles.
  bit resp_en    = 1'b0;
  bit resp_drop  = 1'b1;
  int resp_delay = 1;
  int resp_len   = 3;
  int resp_seen  = 0;
  int frame_left = 0;

  task automatic step();
    @(negedge clk);
    if (frame_left > 0) begin
      frame_left--;
      if (frame_left == 0) begin
        frame_n = 1'b1;
        irdy_n  = 1'b1;
      end
    end else if (resp_en && gnt_valid && frame_n) begin
      resp_seen++;
      if (resp_seen > resp_delay) begin
        frame_n    = 1'b0;
        irdy_n     = 1'b0;
        frame_left = resp_len;
        resp_seen  = 0;
        if (resp_drop) req_n[gnt_id] = 1'b1;
      end
    end else begin
      resp_seen = 0;
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      done = (req_n == 8'hFF) && !gnt_valid && (q_count == 4'd0) && (frame_left == 0) && frame_n;
    end
    check_val({name, "_settle"}, int'(done), 1);
    repeat (3) step();
  endtask

  task automatic clear_logs();
    glog.delete();
    glog_n.delete();
    qpeak = 0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    int low;
    bit seen_g;
    bit ended;
    int idx;

    reset   = 1'b0;
    req_n   = 8'hFF;
    frame_n = 1'b1;
    irdy_n  = 1'b1;
    mode    = 1'b0;
    model_reset();

    repeat (3) step();
    check_val("reset_gnt_n", int'(gnt_n), 8'hFF);
    check_val("reset_gnt_valid", int'(gnt_valid), 0);
    check_val("reset_gnt_id", int'(gnt_id), 0);
    check_val("reset_q_count", int'(q_count), 0);
    #2 reset = 1'b1;

    // Asynchronous reset while a grant is held
    step();
    req_n[2] = 1'b0;
    for (int i = 0; i < 10 && !gnt_valid; i++) step();
    check_val("rst_pre_grant", int'(gnt_valid), 1);
    check_val("rst_pre_q", int'(q_count), 1);
    #2 reset = 1'b0;
    #1;
    check_val("rst_async_gnt_n", int'(gnt_n), 8'hFF);
    check_val("rst_async_q", int'(q_count), 0);
    check_val("rst_async_valid", int'(gnt_valid), 0);
    step();
    req_n = 8'hFF;
    #2 reset = 1'b1;
    repeat (5) step();
    check_val("rst_idle_valid", int'(gnt_valid), 0);
    check_val("rst_idle_q", int'(q_count), 0);

    // FIFO order 5, 2, 7
    clear_logs();
    resp_en = 1'b1; resp_drop = 1'b1; resp_delay = 1; resp_len = 3;
    step(); req_n[5] = 1'b0;
    step(); req_n[2] = 1'b0;
    step(); req_n[7] = 1'b0;
    wait_idle("fifo", 200);
    check_val("fifo_count", glog.size(), 3);
    check_val("fifo_first", glog_at(0), 5);
    check_val("fifo_second", glog_at(1), 2);
    check_val("fifo_third", glog_at(2), 7);
    check_val("fifo_q_peak", qpeak, 3);

    // Fixed priority: 1 before 6
    clear_logs();
    step();
    mode = 1'b1;
    req_n[6] = 1'b0;
    req_n[1] = 1'b0;
    step();
    check_val("prio_first_gnt_n", int'(gnt_n), 8'hFD);
    wait_idle("prio", 200);
    check_val("prio_count", glog.size(), 2);
    check_val("prio_second_id", glog_at(1), 6);
    check_val("prio_second_gnt_n", glog_n_at(1), 8'hBF);
    step();
    mode = 1'b0;
    repeat (2) step();

    // Withdrawn request: 3 leaves the queue before reaching the head
    clear_logs();
    step(); req_n[0] = 1'b0;
    step(); req_n[3] = 1'b0; req_n[4] = 1'b0;
    step();
    step(); req_n[3] = 1'b1;
    wait_idle("withdraw", 200);
    check_val("withdraw_count", glog.size(), 2);
    check_val("withdraw_second_id", glog_at(1), 4);
    check_val("withdraw_gnt_n", glog_n_at(1), 8'hEF);
    check_val("withdraw_q_peak", qpeak, 3);

    // Grant timeout with FRAME# never asserted
    clear_logs();
    resp_en = 1'b0;
    step(); req_n[0] = 1'b0;
    low = 0; seen_g = 1'b0; ended = 1'b0;
    for (int i = 0; i < 60 && !ended; i++) begin
      step();
      if (!gnt_n[0]) begin
        seen_g = 1'b1;
        low++;
      end else if (seen_g) begin
        ended = 1'b1;
      end
    end
    check_val("timeout_hold_cycles", low, 16);
    check_val("timeout_q_after_pop", int'(q_count), 0);
    for (int i = 0; i < 10 && !gnt_valid; i++) step();
    step();
    check_val("timeout_regrant_count", glog.size(), 2);
    check_val("timeout_regrant_id", glog_at(1), 0);
    req_n[0] = 1'b1;
    wait_idle("timeout", 100);

    // All eight request together: queue fills and the pointers wrap
    clear_logs();
    resp_en = 1'b1; resp_drop = 1'b1; resp_delay = 8; resp_len = 3;
    step(); req_n = 8'h00;
    wait_idle("all8", 600);
    check_val("all8_count", glog.size(), 8);
    for (int i = 0; i < 8; i++) check_val($sformatf("all8_order_%0d", i), glog_at(i), i);
    check_val("all8_q_peak", qpeak, 8);

    // Randomized traffic
    resp_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (frame_left == 0 && $urandom_range(0, 19) == 0) begin
        resp_delay = $urandom_range(0, 20);
        resp_len   = $urandom_range(1, 4);
        resp_drop  = 1'($urandom_range(0, 1));
      end
      step();
      if ($urandom_range(0, 4) == 0) begin
        idx = $urandom_range(0, 7);
        req_n[idx] = ~req_n[idx];
      end
      if ($urandom_range(0, 39) == 0) mode = ~mode;
    end
    req_n = 8'hFF;
    mode  = 1'b0;
    wait_idle("random_drain", 300);
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pci_bus_arbiter.md
Name: pci_bus_arbiter

Overview:
Central PCI bus arbiter for up to 8 initiators. It samples REQ#, issues one GNT# at a time, and tracks bus ownership through FRAME#/IRDY#. Two arbitration modes are supported: first-come-first-served using an internal 8-entry request-order queue, and fixed priority. It replaces ad-hoc encoder/FIFO/decoder chaining with one sequenced controller.

Parameters:
N_REQ, 8, number of requesters; fixed at 8 (3-bit IDs).
GNT_TIMEOUT, 16, cycles a grant is held without FRAME# falling before it is revoked.

Ports:
clk  in  1  bus clock; all state updates on posedge.
reset  in  1  asynchronous, active-low reset.
req_n  in  8  REQ# per initiator, active-low.
frame_n  in  1  bus FRAME#, active-low.
irdy_n  in  1  bus IRDY#, active-low.
mode  in  1  0 = FIFO order, 1 = fixed priority (index 0 highest).
gnt_n  out  8  GNT# per initiator, active-low, one-hot-low or all high.
gnt_valid  out  1  high while any gnt_n bit is low.
gnt_id  out  3  index of current or last granted initiator.
q_count  out  4  number of valid queue entries (0..8).

Behaviour:
- Reset (async, active-low): gnt_n=8'hFF, gnt_valid=0, gnt_id=0, q_count=0, read/write pointers=0, pending vector=0, timeout counter=0, state=IDLE.
- All outputs are registered. Inputs are sampled on posedge clk.
- Queue: 8 entries x 3 bits, circular, 3-bit pointers wrap 7->0. It cannot overflow because each initiator holds at most one entry (pending bit).
- Enqueue (mode=0 only): each cycle, the lowest-index i with req_n[i]=0, pending[i]=0 and i not currently granted is written at the tail, and pending[i] is set. Only one enqueue per cycle; other new requesters enqueue on later cycles in index order.
- Pop clears pending for the head entry. A simultaneous enqueue and pop leaves q_count unchanged and advances both pointers.
- If a requester still holds req_n low after being popped, it re-enqueues at the tail (round fairness).
- mode is sampled only in IDLE. When mode=1 is seen in IDLE, the queue is flushed (q_count=0, pointers=0, pending=0) and no enqueues occur. A mode change outside IDLE takes effect on the next IDLE.
- States:
  - IDLE:
    - mode=0, q_count>0, head's req_n high: pop (discard stale entry), stay IDLE.
    - mode=0, head's req_n low: winner = head.
    - mode=1: winner = lowest index with req_n low.
    - On a winner: gnt_n[winner]=0, gnt_id=winner, timeout counter cleared, go to GRANT.
    - No winner: stay IDLE.
  - GRANT:
    - frame_n sampled 0: go to BUSY, release gnt_n (all high), pop head if mode=0.
    - Otherwise, req_n[gnt_id] sampled 1 or counter reaches GNT_TIMEOUT-1: release gnt_n, pop head if mode=0, go to IDLE.
    - Otherwise: increment counter.
  - BUSY: wait until frame_n=1 and irdy_n=1 are sampled together, then go to TURN.
  - TURN: one turnaround cycle with all gnt_n high, then IDLE.
- Latency:
  - mode=1, idle bus: gnt_n low one cycle after the req_n-low edge.
  - mode=0, empty queue: enqueue on edge k, gnt_n low after edge k+1 (2 cycles).
- At most one gnt_n bit is low at any time. Grant never changes owner without an all-high cycle in between.
- Reset mid-transaction: gnt_n goes all high immediately (asynchronously) and the queue is emptied.

Test Plan:
- Reset: hold reset=0 mid-GRANT -> gnt_n=8'hFF, q_count=0 immediately. After release with no requests -> state stays IDLE.
- FIFO order, mode=0: req_n[5] low at cycle 1, req_n[2] at cycle 2, req_n[7] at cycle 3, each master runs a 3-cycle FRAME# then idles -> grants in order 5, 2, 7. q_count peaks at 3.
- Fixed priority, mode=1: req_n[6] and req_n[1] low together -> gnt_n=8'b11111101. After the transaction and TURN -> gnt_n=8'b10111111.
- Withdrawn request: queue [3,4], initiator 3 raises req_n before reaching head -> entry 3 popped without grant, gnt_n=8'b11101111 next, q_count goes 2 -> 1 -> 0 after FRAME#.
- Timeout: grant to initiator 0, frame_n held high for 16 cycles -> gnt_n released on cycle 16, head popped. Initiator 0 re-enqueued if req_n still low.
- Simultaneous: all 8 req_n low in the same cycle, mode=0 -> enqueued 0..7 over 8 cycles, q_count=8, pointer wrap verified. Grants issued in order 0..7.
